// File: rtl/qam16_pkg.sv
// Shared QAM16 definitions for the framer, the mapper and the future deframer.
package qam16_pkg;

  localparam int SYM_W = 4;

  // Preamble corner points: -3-3j and +3+3j on the mapper's constellation.
  localparam logic [SYM_W-1:0] PRE_SYM_A = 4'b0000;
  localparam logic [SYM_W-1:0] PRE_SYM_B = 4'b1111;

  // Framer state encoding; fixed values keep older code that uses the raw codes working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_LO   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PRE  = ST_PRE,
    HI   = ST_HI,
    LO   = ST_LO
  } state_e;

endpackage

// File: rtl/qam16_framer_sym_out_reg.sv
// One-entry valid/ready output register. Holds its symbol while stalled and
// reports whether it can take a new one this cycle.
module sym_out_reg
  import qam16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SYM_W-1:0] load_sym,
  input  logic             load_last,
  input  logic             m_ready,
  output logic             free,
  output logic [SYM_W-1:0] m_sym,
  output logic             m_valid,
  output logic             m_last
);

  assign free = !m_valid || m_ready;

  // Load into a free slot, drain on accept, otherwise hold everything stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_sym   <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_sym   <= load_sym;
      m_last  <= load_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qam16_framer.sv
// QAM16 framer: prepends an alternating corner-point preamble to a payload and
// splits each byte into two symbols, high nibble first.
//
// state | meaning
// IDLE  | no frame; waiting for start
// PRE   | emitting preamble symbols
// HI    | waiting for a payload byte, emits its high nibble
// LO    | emits the stored low nibble of the current byte
module qam16_framer
  import qam16_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int LEN_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [SYM_W-1:0] m_sym,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

  state_e           state, state_d;
  logic [LEN_W-1:0] rem_bytes, rem_d;
  logic [7:0]       pre_cnt, pre_d;
  logic [3:0]       lo_nib, nib_d;

  logic             slot_free;
  logic             load;
  logic [SYM_W-1:0] ld_sym;
  logic             ld_last;

  // A preamble step can come from IDLE (first symbol right on start) or from PRE.
  logic             pre_go;
  logic [7:0]       pre_idx;
  logic [LEN_W-1:0] pre_rem;

  assign busy = (state != IDLE);

  // Next-state and symbol selection; the first preamble symbol loads on the start
  // cycle itself when the slot is free, otherwise PRE picks it up once it frees.
  always_comb begin
    state_d = state;
    rem_d   = rem_bytes;
    pre_d   = pre_cnt;
    nib_d   = lo_nib;
    load    = 1'b0;
    ld_sym  = PRE_SYM_A;
    ld_last = 1'b0;
    s_ready = 1'b0;
    pre_go  = 1'b0;
    pre_idx = pre_cnt;
    pre_rem = rem_bytes;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = PRE;
          rem_d   = frame_len;
          pre_d   = '0;
          pre_go  = slot_free;
          pre_idx = '0;
          pre_rem = frame_len;
        end
      end
      PRE: begin
        pre_go = slot_free;
      end
      HI: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          load    = 1'b1;
          ld_sym  = s_data[7:4];
          nib_d   = s_data[3:0];
          state_d = LO;
        end
      end
      LO: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_sym  = lo_nib;
          ld_last = (rem_bytes == LEN_W'(1));
          if (rem_bytes != '0) rem_d = rem_bytes - LEN_W'(1);
          state_d = (rem_bytes > LEN_W'(1)) ? HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pre_go) begin
      load   = 1'b1;
      ld_sym = pre_idx[0] ? PRE_SYM_B : PRE_SYM_A;
      pre_d  = pre_idx + 8'd1;
      if (pre_idx == PRE_LAST) begin
        ld_last = (pre_rem == '0);
        state_d = (pre_rem == '0) ? IDLE : HI;
      end else begin
        state_d = PRE;
      end
    end
  end

  // Control state; reset drops any frame in flight, including a half-sent byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rem_bytes <= '0;
      pre_cnt   <= '0;
      lo_nib    <= '0;
    end else begin
      state     <= state_d;
      rem_bytes <= rem_d;
      pre_cnt   <= pre_d;
      lo_nib    <= nib_d;
    end
  end

  sym_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_sym  (ld_sym),
    .load_last (ld_last),
    .m_ready   (m_ready),
    .free      (slot_free),
    .m_sym     (m_sym),
    .m_valid   (m_valid),
    .m_last    (m_last)
  );

endmodule

// File: doc/qam16_framer.md
Name: qam16_framer

Overview:
Upstream neighbour of the QAM16 symbol mapper. Takes a payload byte stream and a frame start request, prepends a fixed preamble, and splits each byte into two 4-bit symbols, high nibble first. Its 4-bit symbol output feeds the mapper's data input directly. Both sides use valid/ready flow control.

Parameters:
PREAMBLE_LEN, 8, number of preamble symbols per frame (legal range 1..255).
LEN_W, 8, width of frame_len and of the internal byte counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle frame request; sampled only in IDLE.
frame_len  input  LEN_W  payload length in bytes, captured with start; 0 means a preamble-only frame.
s_data  input  8  payload byte.
s_valid  input  1  s_data valid.
s_ready  output  1  framer accepts s_data this cycle.
m_sym  output  4  symbol to mapper: [3:2] selects I, [1:0] selects Q.
m_valid  output  1  m_sym valid.
m_ready  input  1  downstream accepts m_sym.
m_last  output  1  marks the final symbol of the frame; qualified by m_valid.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, m_valid=0, m_sym=0, m_last=0, s_ready=0, busy=0, counters=0, byte holding register=0.
- Output slot: registered. It is free when m_valid=0, or when m_valid&m_ready. A new symbol loads only into a free slot.
- While m_valid=1 and m_ready=0, m_sym and m_last hold stable.
- If the slot is free and no new symbol loads, m_valid drops to 0 next cycle.
- States: IDLE, PRE, HI, LO.
- IDLE:
  - start=1 captures frame_len into rem_bytes, clears pre_cnt, goes to PRE.
  - start seen in any other state is ignored.
- PRE:
  - Each free-slot cycle loads one preamble symbol. Symbols alternate 4'b0000, 4'b1111, starting with 4'b0000 (corner points -3-3j / +3+3j).
  - pre_cnt increments per loaded symbol.
  - After PREAMBLE_LEN symbols:
    - if rem_bytes=0, the last preamble symbol carries m_last=1 and the state returns to IDLE;
    - otherwise the state goes to HI.
- HI:
  - s_ready = slot free (combinational from m_valid/m_ready and state).
  - On s_valid&s_ready: m_sym=s_data[7:4], s_data[3:0] is stored, state goes to LO.
  - If s_valid=0, the framer waits; this is an underrun and produces no filler.
- LO:
  - s_ready=0. On a free slot: m_sym=stored nibble, rem_bytes decrements.
  - If rem_bytes was 1, m_last=1 and the state goes to IDLE; otherwise the state goes to HI.
- m_last is 0 on every symbol except the final one.
- Latency and throughput:
  - start at cycle N gives the first preamble symbol with m_valid=1 at cycle N+1.
  - With m_ready and s_valid held high, one symbol per cycle, no bubbles.
  - A frame costs PREAMBLE_LEN + 2*frame_len symbol cycles.
- Back-to-back frames: start is accepted in the cycle after the IDLE transition. The final symbol may still be pending in the slot; the new frame's first symbol loads only when the slot frees.
- Reset mid-frame: the frame is aborted immediately, any partial byte is discarded, and no m_last is emitted.
- Width rules: rem_bytes is LEN_W bits and never decrements below 0. pre_cnt is 8 bits.

Decomposition:
- Shared package qam16_pkg holds:
  - state enum (IDLE/PRE/HI/LO);
  - constants PRE_SYM_A=4'b0000 and PRE_SYM_B=4'b1111;
  - SYM_W=4.
- The mapper and a future deframer reuse the package.
- Optional sub-module: sym_out_reg, a one-entry valid/ready output register with hold-on-stall. Otherwise the block is flat.

Test Plan:
- Basic frame: PREAMBLE_LEN=8, start with frame_len=2, bytes 0xA5, 0x3C, m_ready=1 → m_sym 0,F,0,F,0,F,0,F,A,5,3,C on consecutive cycles starting 1 cycle after start; m_last=1 only on C; busy low the cycle after C is accepted.
- Back-pressure: same frame, m_ready toggling 1,0,0,1 → no symbol lost or duplicated; m_sym stable whenever m_valid&!m_ready; s_ready never high while the slot is stalled.
- Underrun: s_valid deasserted 3 cycles before byte 2 → m_valid=0 during the gap, then 3,C follow; m_last on C.
- Preamble-only: frame_len=0 → exactly 8 symbols; m_last on the 8th (4'b1111); s_ready never asserts.
- start ignored while busy: second start pulse mid-payload with frame_len=5 → the current frame completes unchanged; no new frame begins.
- Reset mid-payload: assert rst after symbol A → m_valid, s_ready, busy go 0 immediately (asynchronously); a new start with frame_len=1, byte 0x7E → 8 preamble symbols, 7, E(m_last).
